// File: rtl/instr_pair_supply_pkg.sv
// Shared constants, tracker stage type and pop-count helper for the
// instruction pair supply block.
package instr_pair_supply_pkg;

    localparam int WORD             = 32;
    localparam int QUADWORD         = 128;
    localparam int PAIR_BITS        = QUADWORD / 2;
    localparam int LS_SIZE          = 262144;
    localparam int LS_PAIR_AW       = $clog2(LS_SIZE / 8);
    localparam int INSTR_FIFO_DEPTH = 16;
    localparam int INSTR_LS_LAT     = 3;

    typedef struct packed {
        logic live;
        logic drop_first;
    } track_stage_t;

    // Words handed to decode this cycle, never more than are buffered.
    function automatic logic [1:0] pop_words(input logic stall1,
                                             input logic stall2,
                                             input logic have1,
                                             input logic have2);
        if (stall1) return 2'd0;
        if (stall2) return {1'b0, have1};
        return have2 ? 2'd2 : {1'b0, have1};
    endfunction

endpackage

// File: rtl/instr_pair_supply_if.sv
// Local-store read bus plus decode-side instruction/redirect signals.
interface instr_pair_supply_if
    import instr_pair_supply_pkg::*;
#(
    parameter int AW = LS_PAIR_AW
) ();

    logic                 ls_rd_en;
    logic [AW-1:0]        ls_rd_addr;
    logic [PAIR_BITS-1:0] ls_rd_data;
    logic [WORD-1:0]      instr1;
    logic [WORD-1:0]      instr2;
    logic                 instr1_valid;
    logic                 instr2_valid;
    logic                 dep_stall_instr1;
    logic                 dep_stall_instr2;
    logic                 branch_taken;
    logic [WORD-1:0]      branch_target;
    logic [WORD-1:0]      PC;

    modport master (
        output ls_rd_en, ls_rd_addr, instr1, instr2, instr1_valid, instr2_valid, PC,
        input  ls_rd_data, dep_stall_instr1, dep_stall_instr2, branch_taken, branch_target
    );

    modport slave (
        input  ls_rd_en, ls_rd_addr, instr1, instr2, instr1_valid, instr2_valid, PC,
        output ls_rd_data, dep_stall_instr1, dep_stall_instr2, branch_taken, branch_target
    );

endinterface

// File: rtl/instr_word_fifo.sv
// Circular word FIFO: 0/1/2-word push and pop per cycle, synchronous flush,
// head and head+1 read straight from the storage array.
module instr_word_fifo
    import instr_pair_supply_pkg::*;
#(
    parameter int DEPTH = INSTR_FIFO_DEPTH,
    parameter int W     = WORD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             push_n,
    input  logic [W-1:0]           push_data0,
    input  logic [W-1:0]           push_data1,
    input  logic [1:0]             pop_n,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head_data,
    output logic [W-1:0]           next_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push_n != 2'd0 && !flush) mem[wr_ptr] <= push_data0;
        if (push_n == 2'd2 && !flush) mem[wr_ptr + PW'(1)] <= push_data1;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop_n);
            wr_ptr <= wr_ptr + PW'(push_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + PW'(1)];

endmodule

// File: rtl/instr_pair_supply.sv
// Instruction prefetch: fixed-latency pair reads from local store into a word
// FIFO, presenting the two oldest words to decode, with branch redirect.
module instr_pair_supply #(
    parameter int FIFO_DEPTH = instr_pair_supply_pkg::INSTR_FIFO_DEPTH,
    parameter int LS_LAT     = instr_pair_supply_pkg::INSTR_LS_LAT,
    parameter int LS_PAIR_AW = instr_pair_supply_pkg::LS_PAIR_AW
) (
    input logic                 clk,
    input logic                 reset,
    instr_pair_supply_if.master bus
);

    import instr_pair_supply_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    track_stage_t          track [LS_LAT];
    logic [LS_PAIR_AW-1:0] fetch_ptr;
    logic                  pending_drop;
    logic [WORD-1:0]       pc_q;
    logic [CW-1:0]         count;
    logic [WORD-1:0]       head_data;
    logic [WORD-1:0]       next_data;
    logic [WORD-1:0]       push_data0;
    logic [1:0]            push_n;
    logic [1:0]            pop_n;
    logic                  have1;
    logic                  have2;
    logic                  issue;
    int                    used;

    assign have1 = (count != '0);
    assign have2 = (count > CW'(1));

    // Every live read is reserved as two words, so the exiting stage is already covered.
    always_comb begin
        used = int'(count);
        for (int k = 0; k < LS_LAT; k++) begin
            if (track[k].live) used = used + 2;
        end
        issue = reset && !bus.branch_taken && ((FIFO_DEPTH - used) >= 2);
    end

    always_comb begin
        pop_n = 2'd0;
        if (reset && !bus.branch_taken) begin
            pop_n = pop_words(bus.dep_stall_instr1, bus.dep_stall_instr2, have1, have2);
        end
    end

    // A drop_first pair contributes only its higher-addressed word.
    always_comb begin
        push_n     = 2'd0;
        push_data0 = bus.ls_rd_data[PAIR_BITS-1:WORD];
        if (track[LS_LAT-1].live && !bus.branch_taken && reset) begin
            push_n = track[LS_LAT-1].drop_first ? 2'd1 : 2'd2;
        end
        if (track[LS_LAT-1].drop_first) push_data0 = bus.ls_rd_data[WORD-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_ptr    <= '0;
            pending_drop <= 1'b0;
            pc_q         <= '0;
            for (int k = 0; k < LS_LAT; k++) track[k] <= '0;
        end else if (bus.branch_taken) begin
            fetch_ptr    <= bus.branch_target[LS_PAIR_AW+2:3];
            pending_drop <= bus.branch_target[2];
            pc_q         <= bus.branch_target & ~WORD'(3);
            for (int k = 0; k < LS_LAT; k++) track[k] <= '0;
        end else begin
            track[0] <= {issue, issue && pending_drop};
            for (int k = 1; k < LS_LAT; k++) track[k] <= track[k-1];
            if (issue) begin
                fetch_ptr    <= fetch_ptr + LS_PAIR_AW'(1);
                pending_drop <= 1'b0;
            end
            pc_q <= pc_q + (WORD'(pop_n) << 2);
        end
    end

    instr_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.branch_taken),
        .push_n     (push_n),
        .push_data0 (push_data0),
        .push_data1 (bus.ls_rd_data[WORD-1:0]),
        .pop_n      (pop_n),
        .count      (count),
        .head_data  (head_data),
        .next_data  (next_data)
    );

    assign bus.ls_rd_en     = issue;
    assign bus.ls_rd_addr   = fetch_ptr;
    assign bus.instr1_valid = have1;
    assign bus.instr2_valid = have2;
    assign bus.instr1       = have1 ? head_data : '0;
    assign bus.instr2       = have2 ? next_data : '0;
    assign bus.PC           = pc_q;

endmodule

// File: tb/tb_instr_pair_supply.sv
// Bench for instr_pair_supply: local-store model plus an in-order word
// scoreboard checked whenever decode consumes words.
module tb_instr_pair_supply;

    import instr_pair_supply_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 16;
    localparam int AW    = 15;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    instr_pair_supply_if #(.AW(AW)) bus ();

    instr_pair_supply #(
        .FIFO_DEPTH (DEPTH),
        .LS_LAT     (LAT),
        .LS_PAIR_AW (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Word stored at a byte address; unique over the whole local store.
    function automatic logic [WORD-1:0] word_at(input logic [WORD-1:0] addr);
        return 32'h4000_0000 | {14'b0, addr[17:0]};
    endfunction

    // Local store: answers a request LAT cycles after ls_rd_en.
    logic          req_v [LAT];
    logic [AW-1:0] req_a [LAT];

    always @(posedge clk) begin
        req_v[0] <= bus.ls_rd_en;
        req_a[0] <= bus.ls_rd_addr;
        for (int k = 1; k < LAT; k++) begin
            req_v[k] <= req_v[k-1];
            req_a[k] <= req_a[k-1];
        end
    end

    assign bus.ls_rd_data = req_v[LAT-1]
        ? {word_at({14'b0, req_a[LAT-1], 3'b000}), word_at({14'b0, req_a[LAT-1], 3'b100})}
        : 64'hDEAD_BEEF_DEAD_BEEF;

    // Scoreboard: expected stream loaded when a fetch start is driven.
    logic [WORD-1:0] exp_q [$];
    logic [WORD-1:0] exp_pc;
    bit              sb_on = 1'b0;
    int              sb_popped = 0;

    task automatic sb_start(input logic [WORD-1:0] start);
        exp_q.delete();
        exp_pc = start & ~32'd3;
        for (int i = 0; i < 400; i++) exp_q.push_back(word_at(exp_pc + 32'(4 * i)));
    endtask

    always @(negedge clk) begin
        if (sb_on && reset === 1'b1 && bus.branch_taken === 1'b0) begin
            int n;
            logic [WORD-1:0] got;
            logic [WORD-1:0] want;
            tests_run++;
            if (bus.PC !== exp_pc) begin
                failed++;
                $display("[TB] FAIL sb_pc: got %h, want %h", bus.PC, exp_pc);
            end
            if (bus.dep_stall_instr1) n = 0;
            else if (bus.dep_stall_instr2) n = int'(bus.instr1_valid);
            else n = int'(bus.instr1_valid) + int'(bus.instr2_valid);
            for (int i = 0; i < n; i++) begin
                got = (i == 0) ? bus.instr1 : bus.instr2;
                tests_run++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("[TB] FAIL sb_underflow: got %h, want nothing", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failed++;
                        $display("[TB] FAIL sb_word: got %h, want %h", got, want);
                    end
                end
                sb_popped++;
            end
            exp_pc = exp_pc + 32'(4 * n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.dep_stall_instr1 = 1'b0;
        bus.dep_stall_instr2 = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        repeat (3) tick();
        #1;
        tests_run += 6;
        if (bus.ls_rd_en !== 1'b0) begin failed++; $display("[TB] FAIL reset_en: got %b, want 0", bus.ls_rd_en); end
        if (bus.instr1_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_v1: got %b, want 0", bus.instr1_valid); end
        if (bus.instr2_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_v2: got %b, want 0", bus.instr2_valid); end
        if (bus.instr1 !== 32'h0) begin failed++; $display("[TB] FAIL reset_i1: got %h, want 0", bus.instr1); end
        if (bus.instr2 !== 32'h0) begin failed++; $display("[TB] FAIL reset_i2: got %h, want 0", bus.instr2); end
        if (bus.PC !== 32'h0) begin failed++; $display("[TB] FAIL reset_pc: got %h, want 0", bus.PC); end
    endtask

    task automatic test_first_fetch();
        int first;
        int start_pop;
        first = -1;
        tick();
        reset = 1'b1;
        sb_start(32'h0);
        sb_on = 1'b1;
        start_pop = sb_popped;
        #1;
        tests_run += 2;
        if (bus.ls_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL first_en: got %b, want 1", bus.ls_rd_en); end
        if (bus.ls_rd_addr !== 15'h0) begin failed++; $display("[TB] FAIL first_addr: got %h, want 0", bus.ls_rd_addr); end
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (bus.instr1_valid === 1'b1 && first < 0) first = cyc;
            tick();
            #1;
        end
        tests_run += 2;
        if (first != LAT + 2) begin failed++; $display("[TB] FAIL first_latency: got %0d, want %0d", first, LAT + 2); end
        if (sb_popped - start_pop < 20) begin failed++; $display("[TB] FAIL first_throughput: got %0d, want >=20", sb_popped - start_pop); end
    endtask

    task automatic test_stall2();
        logic [WORD-1:0] a, b, pca;
        bus.dep_stall_instr1 = 1'b1;
        repeat (4) tick();
        bus.dep_stall_instr1 = 1'b0;
        bus.dep_stall_instr2 = 1'b1;
        #1;
        a = bus.instr1;
        b = bus.instr2;
        pca = bus.PC;
        tests_run++;
        if (bus.instr2_valid !== 1'b1) begin failed++; $display("[TB] FAIL stall2_v2: got %b, want 1", bus.instr2_valid); end
        tick();
        bus.dep_stall_instr2 = 1'b0;
        #1;
        tests_run += 3;
        if (bus.instr1 !== b) begin failed++; $display("[TB] FAIL stall2_i1: got %h, want %h", bus.instr1, b); end
        if (bus.instr2 !== word_at(pca + 32'd8)) begin failed++; $display("[TB] FAIL stall2_i2: got %h, want %h", bus.instr2, word_at(pca + 32'd8)); end
        if (bus.PC !== pca + 32'd4) begin failed++; $display("[TB] FAIL stall2_pc: got %h, want %h", bus.PC, pca + 32'd4); end
        if (a !== word_at(pca)) begin tests_run++; failed++; $display("[TB] FAIL stall2_a: got %h, want %h", a, word_at(pca)); end
        else tests_run++;
        repeat (10) tick();
    endtask

    task automatic test_full_stall();
        logic [WORD-1:0] held;
        int en_tail;
        int start_pop;
        en_tail = 0;
        bus.dep_stall_instr1 = 1'b1;
        #1;
        held = bus.instr1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            #1;
            tests_run++;
            if (bus.instr1 !== held) begin failed++; $display("[TB] FAIL full_hold: got %h, want %h", bus.instr1, held); end
            if (cyc >= 17 && bus.ls_rd_en === 1'b1) en_tail++;
        end
        tests_run += 2;
        if (en_tail != 0) begin failed++; $display("[TB] FAIL full_en: got %0d requests, want 0", en_tail); end
        if (bus.instr2_valid !== 1'b1) begin failed++; $display("[TB] FAIL full_v2: got %b, want 1", bus.instr2_valid); end
        bus.dep_stall_instr1 = 1'b0;
        start_pop = sb_popped;
        repeat (8) tick();
        tests_run++;
        if (sb_popped - start_pop < 16) begin failed++; $display("[TB] FAIL full_drain: got %0d, want >=16", sb_popped - start_pop); end
        repeat (20) tick();
    endtask

    task automatic test_redirect();
        logic en1, en2;
        int first;
        first = -1;
        en1 = 1'b0;
        en2 = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            #1;
            en2 = en1;
            en1 = bus.ls_rd_en;
        end
        tests_run++;
        if ({en2, en1} !== 2'b11) begin failed++; $display("[TB] FAIL redir_inflight: got %b, want 11", {en2, en1}); end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_0104;
        sb_start(32'h0000_0104);
        tick();
        bus.branch_taken = 1'b0;
        bus.dep_stall_instr1 = 1'b1;
        #1;
        tests_run += 4;
        if (bus.ls_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL redir_en: got %b, want 1", bus.ls_rd_en); end
        if (bus.ls_rd_addr !== 15'h20) begin failed++; $display("[TB] FAIL redir_addr: got %h, want 0020", bus.ls_rd_addr); end
        if (bus.instr1_valid !== 1'b0) begin failed++; $display("[TB] FAIL redir_flush: got %b, want 0", bus.instr1_valid); end
        if (bus.PC !== 32'h104) begin failed++; $display("[TB] FAIL redir_pc: got %h, want 00000104", bus.PC); end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (bus.instr1_valid === 1'b1 && first < 0) first = cyc;
            tick();
            #1;
        end
        tests_run += 4;
        if (first != LAT + 2) begin failed++; $display("[TB] FAIL redir_latency: got %0d, want %0d", first, LAT + 2); end
        if (bus.instr1 !== word_at(32'h104)) begin failed++; $display("[TB] FAIL redir_i1: got %h, want %h", bus.instr1, word_at(32'h104)); end
        if (bus.instr2 !== word_at(32'h108)) begin failed++; $display("[TB] FAIL redir_i2: got %h, want %h", bus.instr2, word_at(32'h108)); end
        if (bus.PC !== 32'h104) begin failed++; $display("[TB] FAIL redir_pc2: got %h, want 00000104", bus.PC); end
        bus.dep_stall_instr1 = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        int start_pop;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0000_2000;
        sb_start(32'h0000_2000);
        tick();
        bus.branch_target = 32'h0000_300C;
        sb_start(32'h0000_300C);
        tick();
        bus.branch_taken = 1'b0;
        start_pop = sb_popped;
        #1;
        tests_run += 3;
        if (bus.ls_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL b2b_en: got %b, want 1", bus.ls_rd_en); end
        if (bus.ls_rd_addr !== 15'h601) begin failed++; $display("[TB] FAIL b2b_addr: got %h, want 0601", bus.ls_rd_addr); end
        if (bus.PC !== 32'h300C) begin failed++; $display("[TB] FAIL b2b_pc: got %h, want 0000300c", bus.PC); end
        repeat (20) tick();
        tests_run++;
        if (sb_popped - start_pop < 10) begin failed++; $display("[TB] FAIL b2b_stream: got %0d, want >=10", sb_popped - start_pop); end
    endtask

    task automatic test_wrap();
        int start_pop;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h0003_FFF8;
        sb_start(32'h0003_FFF8);
        tick();
        bus.branch_taken = 1'b0;
        start_pop = sb_popped;
        #1;
        tests_run += 2;
        if (bus.ls_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL wrap_en0: got %b, want 1", bus.ls_rd_en); end
        if (bus.ls_rd_addr !== 15'h7FFF) begin failed++; $display("[TB] FAIL wrap_addr0: got %h, want 7fff", bus.ls_rd_addr); end
        tick();
        #1;
        tests_run += 2;
        if (bus.ls_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL wrap_en1: got %b, want 1", bus.ls_rd_en); end
        if (bus.ls_rd_addr !== 15'h0000) begin failed++; $display("[TB] FAIL wrap_addr1: got %h, want 0000", bus.ls_rd_addr); end
        repeat (20) tick();
        tests_run++;
        if (sb_popped - start_pop < 10) begin failed++; $display("[TB] FAIL wrap_stream: got %0d, want >=10", sb_popped - start_pop); end
    endtask

    task automatic test_reset_midstream();
        int start_pop;
        bus.dep_stall_instr1 = 1'b1;
        repeat (20) tick();
        reset = 1'b0;
        sb_on = 1'b0;
        tick();
        #1;
        tests_run += 4;
        if (bus.instr1_valid !== 1'b0) begin failed++; $display("[TB] FAIL mid_v1: got %b, want 0", bus.instr1_valid); end
        if (bus.instr2_valid !== 1'b0) begin failed++; $display("[TB] FAIL mid_v2: got %b, want 0", bus.instr2_valid); end
        if (bus.PC !== 32'h0) begin failed++; $display("[TB] FAIL mid_pc: got %h, want 0", bus.PC); end
        if (bus.ls_rd_en !== 1'b0) begin failed++; $display("[TB] FAIL mid_en: got %b, want 0", bus.ls_rd_en); end
        reset = 1'b1;
        bus.dep_stall_instr1 = 1'b0;
        sb_start(32'h0);
        sb_on = 1'b1;
        start_pop = sb_popped;
        #1;
        tests_run += 2;
        if (bus.ls_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL mid_restart_en: got %b, want 1", bus.ls_rd_en); end
        if (bus.ls_rd_addr !== 15'h0) begin failed++; $display("[TB] FAIL mid_restart_addr: got %h, want 0000", bus.ls_rd_addr); end
        repeat (20) tick();
        tests_run++;
        if (sb_popped - start_pop < 16) begin failed++; $display("[TB] FAIL mid_stream: got %0d, want >=16", sb_popped - start_pop); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall2();
        test_full_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        sb_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/instr_pair_supply.md
Name: instr_pair_supply

Overview:
- Instruction prefetch and supply block. Serves the instruction stream that the fetch/decode front end consumes.
- Issues fixed-latency pair reads (2×32-bit words) to local store, buffers the returned words in a word FIFO, and presents the two oldest words to decode as instr1/instr2.
- Consumes 0, 1 or 2 words per cycle according to the decode dependency stalls.
- Handles branch redirects by flushing the FIFO and discarding in-flight read data.

Parameters:
- FIFO_DEPTH, 16, word entries in the buffer; power of two, ≥4.
- LS_LAT, 3, local-store read latency in cycles from ls_rd_en to ls_rd_data; ≥1.
- LS_PAIR_AW, 15, pair-address width (256 KB local store / 8 B).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ls_rd_en  out  1  pair read request this cycle.
- ls_rd_addr  out  LS_PAIR_AW  pair address (byte address >> 3).
- ls_rd_data  in  64  pair data, LS_LAT cycles after request; bits [0:31] are the lower-addressed word.
- instr1  out  WORD  oldest buffered word.
- instr2  out  WORD  second-oldest buffered word.
- instr1_valid  out  1  instr1 holds a real word.
- instr2_valid  out  1  instr2 holds a real word.
- dep_stall_instr1  in  1  decode cannot accept instr1 (implies instr2 held too).
- dep_stall_instr2  in  1  decode accepts instr1 but not instr2.
- branch_taken  in  1  redirect request.
- branch_target  in  WORD  byte target of the redirect; bits [30:31] ignored.
- PC  out  WORD  byte address of instr1.

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO empty; instr1_valid=0, instr2_valid=0; instr1=instr2=0; PC=0.
  - fetch pointer=0; in-flight tracker cleared; ls_rd_en=0.
  - Fetching starts the first cycle after reset is released. Reset wins over every other input.
- Outputs:
  - instr1/instr2 are FIFO head and head+1, read from registered storage.
  - instrN_valid is set when count > N−1.
- Pop per cycle:
  - dep_stall_instr1=1 → pop 0.
  - dep_stall_instr1=0 and dep_stall_instr2=1 → pop 1 (old instr2 becomes next instr1).
  - Both 0 → pop min(2, count).
  - A pop never exceeds the number of valid words.
  - PC advances by 4 × popped words.
- Fetch:
  - Credit check: free = FIFO_DEPTH − count − 2×inflight. Issue ls_rd_en=1 when free ≥ 2 + 2×(this cycle's pushes not yet counted); compute conservatively so the FIFO never overflows.
  - ls_rd_addr = fetch pointer; the pointer increments by 1 per request and wraps modulo 2^LS_PAIR_AW.
- In-flight tracker:
  - Shift register of LS_LAT stages; each stage carries {live, drop_first}.
  - At a stage-LS_LAT exit with live=1, push both words, or only word 1 when drop_first=1.
  - A push and a pop in the same cycle are both applied.
- Redirect (branch_taken=1):
  - Same cycle: clear the FIFO (valids go 0 next cycle), clear every live bit, ignore the pop.
  - Set PC = target & ~3, and fetch pointer = target[…:28] (pair index).
  - Next cycle: issue the first request with drop_first = target bit 29 (odd word).
  - Redirect wins over a simultaneous pop or push.
  - Back-to-back redirects: the last one wins.
- Boundary conditions:
  - Full FIFO: no request issued; pops still apply.
  - Empty FIFO: valids are 0; stalls are don't-care.
  - Fetch pointer wrap-around at top of local store is seamless.
- Latency: redirect to first valid instr1 = 1 + LS_LAT + 1 cycles.

Decomposition:
- WORD, QUADWORD and LS_SIZE constants live in constants.sv.
- New constants in constants.sv: LS_PAIR_AW and INSTR_FIFO_DEPTH.
- One sub-module, instr_word_fifo: circular word FIFO with 0/1/2-word push and pop, synchronous flush, count output, and head/head+1 read.

Test Plan:
- Reset release, LS returns pairs {0x40200000,0x00000000},… from address 0, no stalls → first valid at cycle 1+LS_LAT+1; instr1/instr2 sequence matches memory; PC steps 0, 8, 16…
- dep_stall_instr2=1 for one cycle with instr1=A, instr2=B → next cycle instr1=B, instr2=C; PC +4.
- dep_stall_instr1=1 held 20 cycles → FIFO fills to 16; ls_rd_en drops; no word lost or duplicated after release.
- branch_taken with target 0x00000104 while 2 reads are in flight → stale data discarded; first instr1 = word at 0x104, instr2 = word at 0x108; PC=0x104.
- Fetch pointer at 0x7FFF → next request address 0x0000; stream continues.
- reset=0 asserted mid-stream with full FIFO → next cycle valids=0, PC=0; after release, fetch restarts from pair 0.
